// File: rtl/proc_chain_scheduler.sv
// -----------------------------------------------------------------------------
// proc_chain_scheduler
//
// Sequences a three-stage HLS chain (A -> B -> C). The stages exchange data
// through paged dual-port BRAMs (AB, AC, BC). Events are tracked with
// free-running issued/completed counters per stage, so several events can be
// in flight at once. No page is reused until stage C has finished with it.
// The bx tag of each event travels with it down the chain.
//
// Ports
//   clk          : clock
//   reset        : asynchronous active-low reset
//   ev_valid     : a new event is available
//   ev_bx        : bx tag of the new event
//   ev_ready     : the event is accepted this cycle (stage A launches)
//   start_a/b/c  : ap_start to stages A/B/C, held high for the whole run
//   done_a/b/c   : ap_done pulses from stages A/B/C
//   bx_a/b/c     : bx tag of the event each stage is running
//   page_a_wr    : AB/AC write page used by A
//   page_b_rd    : AB read page used by B
//   page_b_wr    : BC write page used by B (always equal to page_b_rd)
//   page_c_rd    : BC and AC read page used by C
//   busy         : a stage is running, or events are still in flight
//   err          : sticky; a done pulse arrived while its stage was idle
//   ev_done_cnt  : number of events completed by C (wraps)
// -----------------------------------------------------------------------------
module proc_chain_scheduler #(
  parameter int PAGES  = 2,   // pages per inter-stage memory, power of two
  parameter int PAGE_W = 1,   // clog2(PAGES)
  parameter int BX_W   = 2,   // bx tag width
  parameter int CNT_W  = 8    // event counter width, PAGES <= 2**(CNT_W-1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ev_valid,
  input  logic [BX_W-1:0]   ev_bx,
  output logic              ev_ready,
  output logic              start_a,
  output logic              start_b,
  output logic              start_c,
  input  logic              done_a,
  input  logic              done_b,
  input  logic              done_c,
  output logic [BX_W-1:0]   bx_a,
  output logic [BX_W-1:0]   bx_b,
  output logic [BX_W-1:0]   bx_c,
  output logic [PAGE_W-1:0] page_a_wr,
  output logic [PAGE_W-1:0] page_b_rd,
  output logic [PAGE_W-1:0] page_b_wr,
  output logic [PAGE_W-1:0] page_c_rd,
  output logic              busy,
  output logic              err,
  output logic [CNT_W-1:0]  ev_done_cnt
);

  typedef enum logic {IDLE, RUN} stage_state_e;

  localparam int SA = 0;
  localparam int SB = 1;
  localparam int SC = 2;

  localparam logic [CNT_W-1:0] PAGES_C = CNT_W'(PAGES);

  stage_state_e      state_q     [3];
  stage_state_e      state_d     [3];
  logic [CNT_W-1:0]  issued_q    [3];
  logic [CNT_W-1:0]  completed_q [3];
  logic [PAGE_W-1:0] page_idx    [3];

  logic [2:0] done_vec;
  logic [2:0] ready_vec;  // launch condition, evaluated while the stage is idle
  logic [2:0] launch;     // stage leaves IDLE on this edge
  logic [2:0] finish;     // stage leaves RUN on this edge
  logic [2:0] stray;      // done pulse while the stage is idle

  logic [CNT_W-1:0] occ_a;   // events A has started that C has not finished
  logic [CNT_W-1:0] occ_b;   // events B has started that C has not finished
  logic [CNT_W-1:0] pend_b;  // events A has finished that B has not started
  logic [CNT_W-1:0] pend_c;  // events B has finished that C has not started

  logic [BX_W-1:0]   bx_mem [PAGES];
  logic [PAGE_W-1:0] page_a_q;
  logic [PAGE_W-1:0] page_b_q;
  logic [PAGE_W-1:0] page_c_q;
  logic [BX_W-1:0]   bx_a_q;
  logic [BX_W-1:0]   bx_b_q;
  logic [BX_W-1:0]   bx_c_q;
  logic              err_q;

  assign done_vec = {done_c, done_b, done_a};

  // ---------------------------------------------------------------------------
  // Launch conditions. They use only the registered counters, so a completion
  // in this cycle frees a page one cycle later. The differences wrap modulo
  // 2**CNT_W. This is correct while occupancy stays below 2**(CNT_W-1).
  // ---------------------------------------------------------------------------
  assign occ_a  = issued_q[SA]    - completed_q[SC];
  assign occ_b  = issued_q[SB]    - completed_q[SC];
  assign pend_b = completed_q[SA] - issued_q[SB];
  assign pend_c = completed_q[SB] - issued_q[SC];

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first; a path that leaves one unassigned would infer a latch.
    ready_vec     = '0;
    ready_vec[SA] = ev_valid && (occ_a < PAGES_C);
    ready_vec[SB] = (pend_b != '0) && (occ_b < PAGES_C);
    ready_vec[SC] = (pend_c != '0);
  end

  // PAGES is a power of two, so "count mod PAGES" is just the low bits.
  always_comb begin
    for (int s = 0; s < 3; s++) begin
      page_idx[s] = issued_q[s][PAGE_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage FSMs, process 1 of 3: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples the pre-edge values, whatever order the blocks run in.
    if (!reset) begin
      for (int s = 0; s < 3; s++) state_q[s] <= IDLE;
    end else begin
      for (int s = 0; s < 3; s++) state_q[s] <= state_d[s];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage FSMs, process 2 of 3: next state and per-edge events
  // A stage that finishes always spends at least one cycle in IDLE before it
  // can launch again. This gives a clean falling edge on ap_start.
  // ---------------------------------------------------------------------------
  always_comb begin
    launch = '0;
    finish = '0;
    stray  = '0;
    for (int s = 0; s < 3; s++) begin
      state_d[s] = state_q[s];
      unique case (state_q[s])
        IDLE: begin
          stray[s] = done_vec[s];
          if (ready_vec[s]) begin
            launch[s]  = 1'b1;
            state_d[s] = RUN;
          end
        end
        RUN: begin
          if (done_vec[s]) begin
            finish[s]  = 1'b1;
            state_d[s] = IDLE;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage FSMs, process 3 of 3: outputs
  // ev_ready is masked during reset. The counters already hold zero at that
  // point, so without the mask ev_ready would follow ev_valid.
  // ---------------------------------------------------------------------------
  always_comb begin
    start_a  = (state_q[SA] == RUN);
    start_b  = (state_q[SB] == RUN);
    start_c  = (state_q[SC] == RUN);
    ev_ready = launch[SA] && reset;
    busy     = (state_q[SA] == RUN) || (state_q[SB] == RUN) ||
               (state_q[SC] == RUN) || (issued_q[SA] != completed_q[SC]);
  end

  // ---------------------------------------------------------------------------
  // Event counters. A stray done pulse changes no counter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < 3; s++) begin
        issued_q[s]    <= '0;
        completed_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < 3; s++) begin
        if (launch[s]) issued_q[s]    <= issued_q[s]    + CNT_W'(1);
        if (finish[s]) completed_q[s] <= completed_q[s] + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Page indices and bx tags, captured at launch and stable for the run.
  // A never writes the bx slot that B reads on the same edge.
  // B can only launch when issued_b < issued_a. A can only launch when
  // issued_a - completed_c < PAGES. Since completed_c <= issued_b, the two
  // pages are always different.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the bx slot memory is small and must read back zero after
      // reset, so it is built from resettable flops, not block RAM.
      for (int p = 0; p < PAGES; p++) bx_mem[p] <= '0;
      page_a_q <= '0;
      page_b_q <= '0;
      page_c_q <= '0;
      bx_a_q   <= '0;
      bx_b_q   <= '0;
      bx_c_q   <= '0;
    end else begin
      if (launch[SA]) begin
        page_a_q             <= page_idx[SA];
        bx_a_q               <= ev_bx;
        bx_mem[page_idx[SA]] <= ev_bx;
      end
      if (launch[SB]) begin
        page_b_q <= page_idx[SB];
        bx_b_q   <= bx_mem[page_idx[SB]];
      end
      if (launch[SC]) begin
        page_c_q <= page_idx[SC];
        bx_c_q   <= bx_mem[page_idx[SC]];
      end
    end
  end

  // Sticky protocol error: only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (|stray) begin
      err_q <= 1'b1;
    end
  end

  assign page_a_wr   = page_a_q;
  assign page_b_rd   = page_b_q;
  assign page_b_wr   = page_b_q;
  assign page_c_rd   = page_c_q;
  assign bx_a        = bx_a_q;
  assign bx_b        = bx_b_q;
  assign bx_c        = bx_c_q;
  assign err         = err_q;
  assign ev_done_cnt = completed_q[SC];

endmodule

// File: tb/tb_proc_chain_scheduler.sv
// -----------------------------------------------------------------------------
// tb_proc_chain_scheduler
//
// Self-checking bench for proc_chain_scheduler. CNT_W is 3 so that the event
// counters wrap during the run.
//
// A responder plays each HLS stage. It raises done a programmable number of
// cycles after start (0 means it never answers). A scoreboard queues the bx
// tag of each accepted event. It pops the tag when the next stage launches
// and compares it there, together with the expected page index.
// Directed sequences cover:
//   - timing, page limit and pipelining
//   - a spurious done pulse
//   - reset in mid-run
//   - counter wrap
// -----------------------------------------------------------------------------
module tb_proc_chain_scheduler;

  localparam int PAGES  = 2;
  localparam int PAGE_W = 1;
  localparam int BX_W   = 2;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              ev_valid;
  logic [BX_W-1:0]   ev_bx;
  logic              ev_ready;
  logic              start_a, start_b, start_c;
  logic              done_a, done_b, done_c;
  logic [BX_W-1:0]   bx_a, bx_b, bx_c;
  logic [PAGE_W-1:0] page_a_wr, page_b_rd, page_b_wr, page_c_rd;
  logic              busy, err;
  logic [CNT_W-1:0]  ev_done_cnt;

  logic [2:0] done_resp = '0;   // driven by the stage responders
  logic [2:0] done_force = '0;  // driven directly by the test sequence
  int         lat [3];

  assign done_a = done_resp[0] | done_force[0];
  assign done_b = done_resp[1] | done_force[1];
  assign done_c = done_resp[2] | done_force[2];

  always #5 clk = ~clk;

  proc_chain_scheduler #(
    .PAGES (PAGES),
    .PAGE_W(PAGE_W),
    .BX_W  (BX_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ev_valid   (ev_valid),
    .ev_bx      (ev_bx),
    .ev_ready   (ev_ready),
    .start_a    (start_a),
    .start_b    (start_b),
    .start_c    (start_c),
    .done_a     (done_a),
    .done_b     (done_b),
    .done_c     (done_c),
    .bx_a       (bx_a),
    .bx_b       (bx_b),
    .bx_c       (bx_c),
    .page_a_wr  (page_a_wr),
    .page_b_rd  (page_b_rd),
    .page_b_wr  (page_b_wr),
    .page_c_rd  (page_c_rd),
    .busy       (busy),
    .err        (err),
    .ev_done_cnt(ev_done_cnt)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: stage responders and scoreboard, sampled on the falling edge
  // ---------------------------------------------------------------------------
  logic [BX_W-1:0] q_a[$];
  logic [BX_W-1:0] q_b[$];
  logic [BX_W-1:0] q_c[$];
  int              launches [3] = '{0, 0, 0};
  int              cnt      [3] = '{0, 0, 0};
  int              c_done       = 0;
  bit              chk_done_cnt = 0;
  bit              overlap_seen = 0;
  logic [2:0]      st_prev      = '0;
  logic [2:0]      st;
  logic [BX_W-1:0] exp_bx;

  always @(negedge clk) begin
    st = {start_c, start_b, start_a};
    if (!reset) begin
      q_a.delete();
      q_b.delete();
      q_c.delete();
      for (int i = 0; i < 3; i++) begin
        launches[i] = 0;
        cnt[i]      = 0;
      end
      c_done       = 0;
      chk_done_cnt = 0;
      done_resp    = '0;
      st_prev      = '0;
    end else begin
      if (chk_done_cnt) begin
        check("ev_done_cnt", ev_done_cnt, c_done % (1 << CNT_W));
        chk_done_cnt = 0;
      end
      if (ev_ready) q_a.push_back(ev_bx);
      if ($countones(st) >= 2) overlap_seen = 1;

      if (st[0] && !st_prev[0]) begin
        if (q_a.size() == 0) check("sb_a_empty", 1, 0);
        else begin
          exp_bx = q_a.pop_front();
          check("bx_a", bx_a, exp_bx);
          q_b.push_back(exp_bx);
        end
        check("page_a_wr", page_a_wr, launches[0] % PAGES);
        launches[0]++;
        check("occupancy", (launches[0] - c_done) <= PAGES, 1);
      end
      if (st[1] && !st_prev[1]) begin
        if (q_b.size() == 0) check("sb_b_empty", 1, 0);
        else begin
          exp_bx = q_b.pop_front();
          check("bx_b", bx_b, exp_bx);
          q_c.push_back(exp_bx);
        end
        check("page_b_rd", page_b_rd, launches[1] % PAGES);
        check("page_b_wr", page_b_wr, launches[1] % PAGES);
        launches[1]++;
      end
      if (st[2] && !st_prev[2]) begin
        if (q_c.size() == 0) check("sb_c_empty", 1, 0);
        else begin
          exp_bx = q_c.pop_front();
          check("bx_c", bx_c, exp_bx);
        end
        check("page_c_rd", page_c_rd, launches[2] % PAGES);
        launches[2]++;
      end

      for (int i = 0; i < 3; i++) begin
        if (done_resp[i]) begin
          done_resp[i] = 1'b0;
          cnt[i]       = 0;
        end else if (st[i]) begin
          cnt[i]++;
          if (lat[i] != 0 && cnt[i] >= lat[i]) done_resp[i] = 1'b1;
        end else begin
          cnt[i] = 0;
        end
      end

      // A done seen while C runs completes an event on the coming edge.
      if (st[2] && (done_resp[2] | done_force[2])) begin
        c_done++;
        chk_done_cnt = 1;
      end
      st_prev = st;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequence helpers: inputs change 1 time unit after the rising edge
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    @(posedge clk); #1;
    ev_valid = 1'b0;
    reset    = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic send_event(input logic [BX_W-1:0] bx, input bit keep);
    bit seen = 0;
    @(posedge clk); #1;
    ev_valid = 1'b1;
    ev_bx    = bx;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (ev_ready) seen = 1;
    end
    if (!seen) check("ev_accept_timeout", 0, 1);
    if (!keep) begin
      @(posedge clk); #1;
      ev_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag, input int limit);
    bit idle = 0;
    for (int n = 0; n < limit && !idle; n++) begin
      @(negedge clk);
      if (!busy && !start_a && !start_b && !start_c) idle = 1;
    end
    if (!idle) check({tag, "_idle_timeout"}, 0, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequences
  // ---------------------------------------------------------------------------
  initial begin
    bit found;
    reset      = 1'b0;
    ev_valid   = 1'b0;
    ev_bx      = '0;
    lat        = '{2, 2, 2};
    repeat (3) @(negedge clk);

    // Reset state, with ev_valid high to show that ev_ready stays masked.
    ev_valid = 1'b1;
    #1;
    check("rst_ev_ready", ev_ready, 0);
    check("rst_start", {start_c, start_b, start_a}, 0);
    check("rst_busy_err", {busy, err}, 0);
    check("rst_pages", {page_a_wr, page_b_rd, page_b_wr, page_c_rd}, 0);
    check("rst_bx", {bx_a, bx_b, bx_c}, 0);
    check("rst_done_cnt", ev_done_cnt, 0);
    ev_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;

    // Single event: A runs 5 cycles, B 2 cycles, C 3 cycles.
    lat = '{5, 2, 3};
    @(posedge clk); #1;
    ev_valid = 1'b1;
    ev_bx    = 2'd2;                                    // cycle 0
    @(negedge clk); check("t1_ev_ready", ev_ready, 1);
    @(posedge clk); #1 ev_valid = 1'b0;                 // cycle 1
    @(negedge clk);
    check("t1_start_a", start_a, 1);
    check("t1_page_a", page_a_wr, 0);
    check("t1_bx_a", bx_a, 2);
    check("t1_ev_ready_low", ev_ready, 0);
    repeat (5) @(negedge clk);                          // cycle 6
    check("t1_start_b_c6", start_b, 0);
    @(negedge clk);                                     // cycle 7
    check("t1_start_b_c7", start_b, 1);
    check("t1_bx_b", bx_b, 2);
    repeat (2) @(negedge clk);                          // cycle 9
    check("t1_start_c_c9", start_c, 0);
    @(negedge clk);                                     // cycle 10
    check("t1_start_c_c10", start_c, 1);
    check("t1_bx_c", bx_c, 2);
    wait_idle("t1", 60);
    check("t1_done_cnt", ev_done_cnt, 1);
    check("t1_busy", busy, 0);

    // Page limit: C never answers, so A may only fill both pages.
    do_reset();
    lat = '{2, 2, 0};
    @(posedge clk); #1;
    ev_valid = 1'b1;
    ev_bx    = 2'd1;
    repeat (40) @(negedge clk);
    check("t2_a_launches", launches[0], 2);
    check("t2_ev_ready_stall", ev_ready, 0);
    check("t2_start_a_idle", start_a, 0);
    @(posedge clk); #1 done_force[2] = 1'b1;
    @(posedge clk); #1 done_force[2] = 1'b0;
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (start_a) found = 1;
    end
    check("t2_third_launch", found, 1);
    check("t2_third_page", page_a_wr, 0);
    @(posedge clk); #1 ev_valid = 1'b0;
    lat[2] = 2;
    wait_idle("t2", 200);
    check("t2_a_total", launches[0], 3);
    check("t2_done_cnt", ev_done_cnt, 3);

    // Pipelining: four events, every stage answers after 3 cycles.
    do_reset();
    lat          = '{3, 3, 3};
    overlap_seen = 0;
    for (int i = 0; i < 4; i++) send_event(BX_W'(i), 1'b0);
    wait_idle("t3", 300);
    check("t3_overlap", overlap_seen, 1);
    check("t3_c_launches", launches[2], 4);
    check("t3_done_cnt", ev_done_cnt, 4);

    // Spurious done_b while B is idle.
    check("t4_err_before", err, 0);
    @(posedge clk); #1 done_force[1] = 1'b1;
    @(posedge clk); #1 done_force[1] = 1'b0;
    @(negedge clk);
    check("t4_err_set", err, 1);
    check("t4_busy", busy, 0);
    check("t4_done_cnt", ev_done_cnt, 4);
    repeat (5) @(negedge clk);
    check("t4_no_c_launch", launches[2], 4);
    send_event(2'd1, 1'b0);
    wait_idle("t4", 100);
    check("t4_err_sticky", err, 1);
    check("t4_b_launches", launches[1], 5);
    check("t4_c_launches", launches[2], 5);
    check("t4_done_cnt_after", ev_done_cnt, 5);

    // Reset in mid-run while A and C are both running.
    lat = '{3, 2, 0};
    send_event(2'd2, 1'b0);
    found = 0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge clk);
      if (start_c) found = 1;
    end
    check("t5_c_running", found, 1);
    lat[0] = 0;
    send_event(2'd1, 1'b0);
    @(negedge clk);
    check("t5_pre", {start_c, start_a}, 2'b11);
    #1 reset = 1'b0;
    #1;
    check("t5_async_start", {start_c, start_b, start_a}, 0);
    done_force = 3'b111;                                // ignored during reset
    repeat (2) @(posedge clk);
    #1 done_force = '0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("t5_done_cnt", ev_done_cnt, 0);
    check("t5_pages", {page_a_wr, page_b_rd, page_b_wr, page_c_rd}, 0);
    check("t5_err", err, 0);
    check("t5_busy", busy, 0);
    check("t5_bx", {bx_a, bx_b, bx_c}, 0);
    lat = '{2, 2, 2};
    send_event(2'd3, 1'b0);
    @(negedge clk);
    check("t5_relaunch_page", page_a_wr, 0);
    check("t5_relaunch_bx", bx_a, 3);
    wait_idle("t5", 100);
    check("t5_done_cnt_after", ev_done_cnt, 1);

    // Counter wrap: 20 back-to-back events with 3-bit counters.
    lat = '{1, 2, 1};
    for (int i = 0; i < 20; i++) send_event(BX_W'(i % 4), i != 19);
    wait_idle("t6", 600);
    check("t6_a_launches", launches[0], 21);
    check("t6_c_launches", launches[2], 21);
    check("t6_c_done", c_done, 21);
    check("t6_done_cnt", ev_done_cnt, 21 % (1 << CNT_W));
    check("t6_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
